// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared opcode, instruction field and sequencer state definitions
package fib_pkg;

   localparam int INSTR_W  = 7;
   localparam int OP_MSB   = 6;
   localparam int OP_LSB   = 4;
   localparam int OPR1_MSB = 3;
   localparam int OPR1_LSB = 2;
   localparam int OPR2_MSB = 1;
   localparam int OPR2_LSB = 0;

   localparam logic [2:0] OP_NOOP  = 3'b000;
   localparam logic [2:0] OP_SET   = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_LOAD  = 3'b100;
   localparam logic [2:0] OP_STORE = 3'b101;
   localparam logic [2:0] OP_MOVE  = 3'b110;
   localparam logic [2:0] OP_COPY  = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_FIN    = 3'd5
   } seq_state_t;

   function automatic logic is_mem_op(input logic [2:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - fetch/execute controller with loop counter and data-memory handshake
module prog_sequencer
   import fib_pkg::*;
#(
   parameter int PC_W  = 4,
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [PC_W-1:0]     loop_pc,
   input  logic [PC_W-1:0]     last_pc,
   input  logic [CNT_W-1:0]    n_iter,
   output logic [PC_W-1:0]     instr_addr,
   input  logic [INSTR_W-1:0]  instr_in,
   output logic [2:0]          op_code,
   output logic [1:0]          opr1,
   output logic [1:0]          opr2,
   output logic                exec_en,
   output logic                mem_req,
   output logic                mem_we,
   input  logic                mem_ack,
   output logic                busy,
   output logic                done
);

   seq_state_t          state;
   logic [PC_W-1:0]     pc;
   logic [PC_W-1:0]     loop_r;
   logic [PC_W-1:0]     last_r;
   logic [CNT_W-1:0]    iter;
   logic [INSTR_W-1:0]  ir;
   logic [2:0]          fetched_op;
   logic                instr_done;

   assign fetched_op = instr_in[OP_MSB:OP_LSB];
   assign instr_addr = pc;
   assign op_code    = ir[OP_MSB:OP_LSB];
   assign opr1       = ir[OPR1_MSB:OPR1_LSB];
   assign opr2       = ir[OPR2_MSB:OPR2_LSB];

   // A load completes in its ack cycle, so the write strobe must follow mem_ack directly.
   assign instr_done = (state == S_EXEC) || ((state == S_MEM) && mem_ack);
   assign exec_en    = (state == S_EXEC) || ((state == S_MEM) && mem_ack && !mem_we);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         pc      <= '0;
         loop_r  <= '0;
         last_r  <= '0;
         iter    <= '0;
         ir      <= '0;
         mem_req <= 1'b0;
         mem_we  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  pc     <= '0;
                  loop_r <= loop_pc;
                  last_r <= last_pc;
                  iter   <= (n_iter == '0) ? CNT_W'(1) : n_iter;
                  busy   <= 1'b1;
                  state  <= S_FETCH;
               end
            end
            S_FETCH: state <= S_DECODE;
            S_DECODE: begin
               ir <= instr_in;
               if (is_mem_op(fetched_op)) begin
                  mem_req <= 1'b1;
                  mem_we  <= (fetched_op == OP_STORE);
                  state   <= S_MEM;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_MEM: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
               end
            end
            S_EXEC: ;
            S_FIN: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase

         // Shared advance step for both execute and memory completion.
         if (instr_done) begin
            if (pc != last_r) begin
               pc    <= pc + PC_W'(1);
               state <= S_FETCH;
            end else if (iter > CNT_W'(1)) begin
               iter  <= iter - CNT_W'(1);
               pc    <= loop_r;
               state <= S_FETCH;
            end else begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_FIN;
            end
         end
      end
   end

endmodule
